mem_arbiter: RTL and testbench

Shares the single main-memory port between three requesters: instruction-cache refill, data-cache refill and data-cache dirty write-back. Each requester raises a level request, and the arbiter runs one memory transaction at a time. It returns a one-cycle acknowledge, plus the fill line for reads. It sits between the cache stages and the memory model, replacing direct pokes of shared request registers with a sequenced handshake.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side request/ack bundle plus memory-port signals for mem_arbiter.
//   master: arbiter view. Requests, addresses, write line, mem_ready and mem_rdata are inputs.
//           Acks, fillData and the mem_* transaction signals are outputs.
//   slave:  environment view (requesters plus memory), with every direction reversed.
interface mem_arbiter_if #(
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 128
);
    logic                 reqI;
    logic [ADDR_W-1:0]    reqAddrI;
    logic                 reqD;
    logic [ADDR_W-1:0]    reqAddrD;
    logic                 reqW;
    logic [ADDR_W-1:0]    writeAddr;
    logic [LINE_BITS-1:0] writeData;
    logic                 ackI;
    logic                 ackD;
    logic                 ackW;
    logic [LINE_BITS-1:0] fillData;
    logic                 mem_req;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [LINE_BITS-1:0] mem_wdata;
    logic                 mem_ready;
    logic [LINE_BITS-1:0] mem_rdata;

    modport master (
        input  reqI, reqAddrI, reqD, reqAddrD, reqW, writeAddr, writeData, mem_ready, mem_rdata,
        output ackI, ackD, ackW, fillData, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output reqI, reqAddrI, reqD, reqAddrD, reqW, writeAddr, writeData, mem_ready, mem_rdata,
        input  ackI, ackD, ackW, fillData, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: runs one main-memory transaction at a time for I-refill, D-refill and D write-back.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mem_arbiter_if.master (requester handshakes and the memory port)
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 128
) (
    input logic           clock,
    input logic           reset,
    mem_arbiter_if.master bus
);
    localparam int OFF = $clog2(LINE_BITS / 8);
    localparam logic [ADDR_W-1:0] MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WRITE  = 3'd1;
    localparam logic [2:0] READ_D = 3'd2;
    localparam logic [2:0] READ_I = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    logic [2:0]           state;
    logic                 last_i;
    logic                 req;
    logic                 we;
    logic                 ack_i;
    logic                 ack_d;
    logic                 ack_w;
    logic [ADDR_W-1:0]    addr;
    logic [LINE_BITS-1:0] wdata;
    logic [LINE_BITS-1:0] fill;
    logic                 pick_d;

    // D takes a read tie only when I was the last read served
    assign pick_d = bus.reqD && (!bus.reqI || last_i);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            last_i <= 1'b1;
            req    <= 1'b0;
            we     <= 1'b0;
            ack_i  <= 1'b0;
            ack_d  <= 1'b0;
            ack_w  <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
            fill   <= '0;
        end else begin
            ack_i <= 1'b0;
            ack_d <= 1'b0;
            ack_w <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.reqW) begin
                        state <= WRITE;
                        req   <= 1'b1;
                        we    <= 1'b1;
                        addr  <= bus.writeAddr & MASK;
                        wdata <= bus.writeData;
                    end else if (pick_d) begin
                        state <= READ_D;
                        req   <= 1'b1;
                        we    <= 1'b0;
                        addr  <= bus.reqAddrD & MASK;
                    end else if (bus.reqI) begin
                        state <= READ_I;
                        req   <= 1'b1;
                        we    <= 1'b0;
                        addr  <= bus.reqAddrI & MASK;
                    end
                end
                WRITE, READ_D, READ_I: begin
                    if (bus.mem_ready) begin
                        state <= RESP;
                        req   <= 1'b0;
                        ack_w <= (state == WRITE);
                        ack_d <= (state == READ_D);
                        ack_i <= (state == READ_I);
                        if (state != WRITE) begin
                            fill   <= bus.mem_rdata;
                            last_i <= (state == READ_I);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ackI      = ack_i;
    assign bus.ackD      = ack_d;
    assign bus.ackW      = ack_w;
    assign bus.fillData  = fill;
    assign bus.mem_req   = req;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter dut (.clock(clk), .reset(rst_n), .bus(bus));

    // requester index: 0 = I refill, 1 = D refill, 2 = write-back
    logic [2:0]   req = '0;
    logic [31:0]  addr [3] = '{0, 0, 0};
    logic [127:0] wdat = '0;
    int           want [3] = '{0, 0, 0};
    logic         rnd = 1'b0;
    logic         rnd_lat = 1'b0;
    int           lat = 0;
    int           cur_lat = 0;
    int           cnt = 0;
    logic         mready = 1'b0;
    logic [127:0] rdata = '0;
    logic [2:0]   ack_q = '0;

    int errors = 0;
    int checks = 0;
    int gl[$];
    logic [31:0] ga[$];
    int acks_seen = 0;

    logic [2:0]   prev_req = '0;
    logic [31:0]  prev_addr [3] = '{0, 0, 0};
    logic [127:0] prev_wdat = '0;
    logic         prev_mreq = 1'b0;
    logic [127:0] m_fill = '0;
    logic         m_last_i = 1'b1;
    logic         done = 1'b0;
    int           cur = 0;
    int           idle = 0;
    logic [31:0]  hold_addr = '0;
    logic [127:0] hold_wd = '0;
    logic         hold_we = 1'b0;
    logic [2:0]   ackv;

    assign bus.reqI      = req[0];
    assign bus.reqD      = req[1];
    assign bus.reqW      = req[2];
    assign bus.reqAddrI  = addr[0];
    assign bus.reqAddrD  = addr[1];
    assign bus.writeAddr = addr[2];
    assign bus.writeData = wdat;
    assign bus.mem_ready = mready;
    assign bus.mem_rdata = rdata;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int t = 0;
        while (acks_seen < n && t < budget) begin
            step(1);
            t++;
        end
        chk("tx_timeout", acks_seen >= n, 1'b1);
    endtask

    // requesters: raise when asked, drop on the edge that ends the ack cycle
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (ack_q[i]) req[i] = 1'b0;
            else if (!req[i] && want[i] > 0 && (!rnd || $urandom_range(0, 3) == 0)) begin
                if (rnd) addr[i] = $urandom;
                if (rnd && i == 2) wdat = {$urandom, $urandom, $urandom, $urandom};
                req[i] = 1'b1;
                want[i]--;
            end
        end
    end

    // memory: ready after cur_lat wait cycles of mem_req, fresh random line per transaction
    always @(posedge clk) begin
        #1;
        if (!bus.mem_req) begin
            mready = 1'b0;
            cnt = 0;
        end else begin
            if (cnt == 0) cur_lat = rnd_lat ? int'($urandom_range(0, 4)) : lat;
            mready = (cnt == cur_lat);
            if (mready) rdata = {$urandom, $urandom, $urandom, $urandom};
            cnt++;
        end
    end

    // transaction-level reference: priority W > tie-broken reads, one transaction at a time
    always @(negedge clk) begin
        ackv = {bus.ackW, bus.ackD, bus.ackI};
        ack_q = ackv;
        if (!rst_n) begin
            m_last_i = 1'b1;
            m_fill = '0;
            done = 1'b0;
            idle = 0;
        end else begin
            chk("ack", ackv, done ? 3'(1 << cur) : 3'b000);
            chk("fill", bus.fillData, m_fill);
            if (done) begin
                chk("req_drop", bus.mem_req, 1'b0);
                acks_seen++;
                done = 1'b0;
            end
            if (bus.mem_req && !prev_mreq) begin
                chk("grant_any", prev_req != 3'b000, 1'b1);
                cur = prev_req[2] ? 2 : (prev_req[1] && (!prev_req[0] || m_last_i)) ? 1 : 0;
                chk("we", bus.mem_we, cur == 2);
                chk("addr", bus.mem_addr, (prev_addr[cur] / 16) * 16);
                if (cur == 2) chk("wdata", bus.mem_wdata, prev_wdat);
                hold_addr = bus.mem_addr;
                hold_wd = bus.mem_wdata;
                hold_we = bus.mem_we;
                gl.push_back(cur);
                ga.push_back(bus.mem_addr);
            end else if (bus.mem_req) begin
                chk("addr_hold", bus.mem_addr, hold_addr);
                chk("wdata_hold", bus.mem_wdata, hold_wd);
                chk("we_hold", bus.mem_we, hold_we);
            end
            if (bus.mem_req && bus.mem_ready) begin
                done = 1'b1;
                if (cur != 2) begin
                    m_fill = bus.mem_rdata;
                    m_last_i = (cur == 0);
                end
            end
            idle = (req != 3'b000 && !bus.mem_req && ackv == 3'b000) ? idle + 1 : 0;
            chk("starve", idle > 2, 1'b0);
        end
        prev_req = req;
        prev_addr = addr;
        prev_wdat = wdat;
        prev_mreq = rst_n && bus.mem_req;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int t0;
        int t;
        rst_n = 1'b0;
        step(3);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_acks", {bus.ackW, bus.ackD, bus.ackI}, 3'b000);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 128'h0);
        chk("rst_fill", bus.fillData, 128'h0);
        rst_n = 1'b1;
        step(2);

        lat = 2;
        addr[1] = 32'h0000_1234;
        want[1] = 1;
        wait_tx(1, 50);
        chk("d_owner", gl[0], 1);
        chk("d_addr", ga[0], 32'h0000_1230);
        chk("d_fill", bus.fillData, rdata);

        step(2);
        lat = 1;
        addr[2] = 32'h40;
        wdat = {16{8'hA5}};
        addr[1] = 32'h80;
        n = gl.size();
        t0 = acks_seen;
        want[2] = 1;
        want[1] = 1;
        wait_tx(t0 + 2, 100);
        chk("evict_first", gl[n], 2);
        chk("evict_addr", ga[n], 32'h40);
        chk("refill_next", gl[n + 1], 1);
        chk("refill_addr", ga[n + 1], 32'h80);

        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        lat = 0;
        n = gl.size();
        t0 = acks_seen;
        want[0] = 4;
        want[1] = 4;
        wait_tx(t0 + 8, 200);
        for (int k = 0; k < 8; k++) chk("fair", gl[n + k], (k % 2 == 0) ? 1 : 0);

        step(2);
        lat = 6;
        addr[0] = $urandom;
        n = gl.size();
        t0 = acks_seen;
        want[0] = 1;
        step(4);
        addr[1] = $urandom;
        addr[2] = $urandom;
        want[1] = 1;
        want[2] = 1;
        wait_tx(t0 + 3, 200);
        chk("pre_i", gl[n], 0);
        chk("pre_w", gl[n + 1], 2);
        chk("pre_d", gl[n + 2], 1);

        step(2);
        lat = 20;
        addr[2] = $urandom;
        wdat = {$urandom, $urandom, $urandom, $urandom};
        t0 = acks_seen;
        want[2] = 1;
        wait_tx(t0 + 1, 100);
        step(5);
        chk("slow_one_ack", acks_seen - t0, 1);

        step(2);
        lat = 30;
        addr[1] = 32'h0000_2000;
        n = gl.size();
        want[1] = 1;
        step(6);
        chk("mid_read_busy", bus.mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_mem_req", bus.mem_req, 1'b0);
        chk("async_acks", {bus.ackW, bus.ackD, bus.ackI}, 3'b000);
        chk("async_fill", bus.fillData, 128'h0);
        chk("async_addr", bus.mem_addr, 32'h0);
        step(2);
        lat = 1;
        t0 = acks_seen;
        rst_n = 1'b1;
        wait_tx(t0 + 1, 50);
        chk("regrant_owner", gl[n + 1], 1);
        chk("regrant_addr", ga[n + 1], 32'h0000_2000);

        step(2);
        rnd = 1'b1;
        rnd_lat = 1'b1;
        want = '{300, 300, 300};
        step(1500);
        want = '{0, 0, 0};
        t = 0;
        while ((req != 3'b000 || bus.mem_req) && t < 200) begin
            step(1);
            t++;
        end
        chk("drain", req == 3'b000 && !bus.mem_req, 1'b1);
        step(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
